// File: rtl/alu_pkg.sv
// Shared types and constants for the 6-bit ALU: widths, opcodes, loader FSM states, stage LED codes.
package alu_pkg;

    localparam int DATA_W = 6;
    localparam int OP_W   = 3;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_ADD = 3'd0;
    localparam opcode_t OP_SUB = 3'd1;
    localparam opcode_t OP_MUL = 3'd2;
    localparam opcode_t OP_AND = 3'd3;
    localparam opcode_t OP_OR  = 3'd4;
    localparam opcode_t OP_XOR = 3'd5;
    localparam opcode_t OP_MAX = OP_XOR;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_HOLD
    } state_t;

    // S_EXEC and S_HOLD share one LED code.
    localparam logic [1:0] STAGE_A    = 2'd0;
    localparam logic [1:0] STAGE_B    = 2'd1;
    localparam logic [1:0] STAGE_OP   = 2'd2;
    localparam logic [1:0] STAGE_HOLD = 2'd3;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button front end: 2-FF synchronizer, optional debounce (DEBOUNCE_EN), rising-edge detect.
// Produces a single-cycle pulse per press; a held button yields one pulse only.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync_1;
    logic sync_2;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             level;

    // The accepted level flips only after the opposite level has been seen for
    // DEBOUNCE_CYCLES consecutive samples; this applies to release as well as press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_2;
                cnt   <= '0;
                pulse <= sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= sync_2;
        end
    end

    assign pulse = sync_2 & ~prev;
`endif

endmodule

// File: rtl/alu_operand_loader.sv
// Sequential operand/opcode loader for the 6-bit ALU: one Enter press per item, then a start strobe.
// Optional build macro DEBOUNCE_EN enables the button debounce counter.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_enter,
    input  logic              clr,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [OP_W-1:0]   op_code,
    output logic              start,
    output logic              op_err,
    output logic [1:0]        stage
);

    logic   ent;
    state_t state;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_enter),
        .pulse(ent)
    );

    // All outputs are registered alongside the state, so stage/start change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_A;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            op_err  <= 1'b0;
            start   <= 1'b0;
            stage   <= STAGE_A;
        end else if (clr) begin
            // clr wins over a coincident ent; that press is simply dropped.
            state   <= S_A;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            op_err  <= 1'b0;
            start   <= 1'b0;
            stage   <= STAGE_A;
        end else begin
            start <= 1'b0;
            case (state)
                S_A: begin
                    if (ent) begin
                        op_a  <= sw;
                        state <= S_B;
                        stage <= STAGE_B;
                    end
                end
                S_B: begin
                    if (ent) begin
                        op_b  <= sw;
                        state <= S_OP;
                        stage <= STAGE_OP;
                    end
                end
                S_OP: begin
                    if (ent) begin
                        if (sw[OP_W-1:0] <= OP_MAX) begin
                            op_code <= sw[OP_W-1:0];
                            op_err  <= 1'b0;
                            start   <= 1'b1;
                            state   <= S_EXEC;
                            stage   <= STAGE_HOLD;
                        end else begin
                            op_err <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    // A press here loads the next A directly, skipping a separate "new op" press.
                    if (ent) begin
                        op_a  <= sw;
                        state <= S_B;
                        stage <= STAGE_B;
                    end
                end
                default: begin
                    state <= S_A;
                    stage <= STAGE_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a start-strobe scoreboard running beside the stimulus.
module tb_alu_operand_loader;

    logic       clk;
    logic       rst_n;
    logic [5:0] sw;
    logic       btn_enter;
    logic       clr;
    logic [5:0] op_a;
    logic [5:0] op_b;
    logic [2:0] op_code;
    logic       start;
    logic       op_err;
    logic [1:0] stage;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    alu_operand_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_enter(btn_enter),
        .clr      (clr),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_code  (op_code),
        .start    (start),
        .op_err   (op_err),
        .stage    (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raw press: ent acts on the second posedge after the first sample; sw stays put through it.
    task automatic press(input logic [5:0] v);
        @(negedge clk);
        sw        = v;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_exp(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.op = op;
        exp_q.push_back(e);
    endtask

    initial begin
        logic       prev_start;
        logic       bad;
        logic [5:0] ha;
        logic [5:0] hb;
        logic [2:0] hc;

        checks     = 0;
        errors     = 0;
        prev_start = 1'b0;
        rst_n      = 1'b0;
        sw         = '0;
        btn_enter  = 1'b0;
        clr        = 1'b0;

        // Scoreboard monitor: every start strobe must match the oldest expected operation.
        fork
            forever begin
                @(negedge clk);
                if (start) begin
                    check("start_back_to_back", {31'd0, prev_start}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("start_unexpected", {31'd0, start}, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_op_a", {26'd0, op_a}, {26'd0, e.a});
                        check("sb_op_b", {26'd0, op_b}, {26'd0, e.b});
                        check("sb_op_code", {29'd0, op_code}, {29'd0, e.op});
                    end
                end
                prev_start = start;
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_op_a", {26'd0, op_a}, 32'd0);
        check("rst_op_b", {26'd0, op_b}, 32'd0);
        check("rst_op_code", {29'd0, op_code}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_op_err", {31'd0, op_err}, 32'd0);
        check("rst_stage", {30'd0, stage}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Multiply entry: -3 * 5.
        press(6'b111101);
        check("mul_stage_b", {30'd0, stage}, 32'd1);
        press(6'b000101);
        check("mul_stage_op", {30'd0, stage}, 32'd2);
        push_exp(6'h3D, 6'h05, 3'd2);
        press(6'd2);
        check("mul_stage_hold", {30'd0, stage}, 32'd3);
        ha  = op_a;
        hb  = op_b;
        hc  = op_code;
        bad = 1'b0;
        sw  = 6'h2A;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (op_a !== 6'h3D || op_b !== 6'h05 || op_code !== 3'd2 || start !== 1'b0 || stage !== 2'd3)
                bad = 1'b1;
        end
        check("hold_stable", {31'd0, bad}, 32'd0);
        check("hold_op_a", {26'd0, ha}, 32'h3D);
        check("hold_op_code", {29'd0, hc}, 32'd2);
        check("hold_op_b", {26'd0, hb}, 32'h05);

        // From S_HOLD a press loads the next A (-32) directly.
        press(6'h20);
        check("hold_next_op_a", {26'd0, op_a}, 32'h20);
        check("hold_next_stage", {30'd0, stage}, 32'd1);
        check("hold_next_op_b", {26'd0, op_b}, 32'h05);

        // Illegal opcodes 6 and 7, then 0 with junk in the upper switch bits.
        press(6'h0A);
        press(6'd6);
        check("ill6_op_err", {31'd0, op_err}, 32'd1);
        check("ill6_stage", {30'd0, stage}, 32'd2);
        press(6'd7);
        check("ill7_op_err", {31'd0, op_err}, 32'd1);
        check("ill7_stage", {30'd0, stage}, 32'd2);
        check("ill7_op_code", {29'd0, op_code}, 32'd2);
        push_exp(6'h20, 6'h0A, 3'd0);
        press(6'b111000);
        check("legal0_op_err", {31'd0, op_err}, 32'd0);
        check("legal0_op_code", {29'd0, op_code}, 32'd0);
        check("legal0_stage", {30'd0, stage}, 32'd3);

        // Synchronous clear from S_HOLD.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_stage", {30'd0, stage}, 32'd0);
        check("clr_op_a", {26'd0, op_a}, 32'd0);
        check("clr_op_b", {26'd0, op_b}, 32'd0);

        // Held button: one ent only.
        @(negedge clk);
        sw        = 6'h11;
        btn_enter = 1'b1;
        repeat (50) @(negedge clk);
        check("held_stage", {30'd0, stage}, 32'd1);
        check("held_op_a", {26'd0, op_a}, 32'h11);
        btn_enter = 1'b0;
        repeat (4) @(negedge clk);

        // Clear again, then clr coincident with ent in S_B: press is discarded.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        press(6'h0C);
        check("pre_clr_stage", {30'd0, stage}, 32'd1);
        @(negedge clk);
        sw        = 6'h15;
        btn_enter = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_ent_stage", {30'd0, stage}, 32'd0);
        check("clr_ent_op_a", {26'd0, op_a}, 32'd0);
        check("clr_ent_op_b", {26'd0, op_b}, 32'd0);

        // Highest legal opcode.
        press(6'h1F);
        press(6'h1E);
        push_exp(6'h1F, 6'h1E, 3'd5);
        press(6'd5);
        check("opmax_stage", {30'd0, stage}, 32'd3);
        check("opmax_op_err", {31'd0, op_err}, 32'd0);

        // Asynchronous reset pulse in the middle of S_EXEC.
        press(6'h01);
        press(6'h02);
        @(negedge clk);
        sw        = 6'd3;
        btn_enter = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("exec_start_pre_rst", {31'd0, start}, 32'd1);
        rst_n     = 1'b0;
        btn_enter = 1'b0;
        #1;
        rst_n = 1'b1;
        check("arst_start", {31'd0, start}, 32'd0);
        check("arst_op_a", {26'd0, op_a}, 32'd0);
        check("arst_op_b", {26'd0, op_b}, 32'd0);
        check("arst_op_code", {29'd0, op_code}, 32'd0);
        check("arst_stage", {30'd0, stage}, 32'd0);
        repeat (4) @(negedge clk);
        check("arst_stage_after", {30'd0, stage}, 32'd0);

        check("sb_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
